// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial frame feeder: MSB-first bit stream with frame markers and an idle gap.
// Optional even-parity trailer bit enabled by defining SERIAL_FEEDER_PARITY_EN.
module serial_frame_feeder #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [FLEN-1:0] sreg, sreg_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [3:0]      gap_cnt, gap_cnt_nxt;
    logic            bit_out_nxt, bit_valid_nxt, frame_start_nxt, frame_last_nxt;
    logic [FLEN-1:0] load_word;
    logic            final_bit;
    logic            xfer;

`ifdef SERIAL_FEEDER_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    // bit_cnt indexes the bit currently on bit_out
    assign final_bit = (state == S_SHIFT) && (bit_cnt == CW'(FLEN - 1));
    assign in_ready  = !rst && ((state == S_IDLE) || (final_bit && (GAP == 0)));
    assign xfer      = in_valid && in_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt       = state;
        sreg_nxt        = sreg;
        bit_cnt_nxt     = bit_cnt;
        gap_cnt_nxt     = gap_cnt;
        bit_out_nxt     = 1'b0;
        bit_valid_nxt   = 1'b0;
        frame_start_nxt = 1'b0;
        frame_last_nxt  = 1'b0;
        if (xfer) begin
            state_nxt       = S_SHIFT;
            bit_out_nxt     = load_word[FLEN-1];
            sreg_nxt        = load_word << 1;
            bit_cnt_nxt     = '0;
            bit_valid_nxt   = 1'b1;
            frame_start_nxt = 1'b1;
            frame_last_nxt  = (FLEN == 1);
        end else begin
            case (state)
                S_SHIFT: begin
                    if (final_bit) begin
                        state_nxt   = (GAP > 0) ? S_GAP : S_IDLE;
                        gap_cnt_nxt = '0;
                        sreg_nxt    = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_out_nxt    = sreg[FLEN-1];
                        sreg_nxt       = sreg << 1;
                        bit_cnt_nxt    = bit_cnt + CW'(1);
                        bit_valid_nxt  = 1'b1;
                        frame_last_nxt = ((bit_cnt + CW'(1)) == CW'(FLEN - 1));
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'(GAP - 1)) begin
                        state_nxt   = S_IDLE;
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            state       <= state_nxt;
            sreg        <= sreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            bit_out     <= bit_out_nxt;
            bit_valid   <= bit_valid_nxt;
            frame_start <= frame_start_nxt;
            frame_last  <= frame_last_nxt;
        end
    end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: three configurations (8/1, 8/0, 1/2) with directed and random traffic.
module tb_serial_frame_feeder;

    localparam int NI = 3;
    localparam int W0 = 8, G0 = 1;
    localparam int W1 = 8, G1 = 0;
    localparam int W2 = 1, G2 = 2;

    typedef struct packed {
        logic v;
        logic b;
        logic s;
        logic l;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    d [NI];
    logic [NI-1:0] v;
    wire  [NI-1:0] rdy, bo, bv, fs, fl, bsy;

    int   iw [NI] = '{W0, W1, W2};
    int   ig [NI] = '{G0, G1, G2};
    cyc_t exp_q [NI][$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_frame_feeder #(.WIDTH(W0), .GAP(G0)) dut0 (
        .clk(clk), .rst(rst), .in_data(d[0]), .in_valid(v[0]), .in_ready(rdy[0]),
        .bit_out(bo[0]), .bit_valid(bv[0]), .frame_start(fs[0]), .frame_last(fl[0]), .busy(bsy[0])
    );
    serial_frame_feeder #(.WIDTH(W1), .GAP(G1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d[1]), .in_valid(v[1]), .in_ready(rdy[1]),
        .bit_out(bo[1]), .bit_valid(bv[1]), .frame_start(fs[1]), .frame_last(fl[1]), .busy(bsy[1])
    );
    serial_frame_feeder #(.WIDTH(W2), .GAP(G2)) dut2 (
        .clk(clk), .rst(rst), .in_data(d[2][0:0]), .in_valid(v[2]), .in_ready(rdy[2]),
        .bit_out(bo[2]), .bit_valid(bv[2]), .frame_start(fs[2]), .frame_last(fl[2]), .busy(bsy[2])
    );

    function automatic int flen_of(int w);
`ifdef SERIAL_FEEDER_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    // k-th transmitted bit of a word: data MSB first, then even parity if present
    function automatic logic frame_bit(logic [7:0] word, int w, int k);
        logic p;
        p = 1'b0;
        for (int j = 0; j < w; j++) p = p ^ word[j];
        if (k < w) return word[w-1-k];
        return p;
    endfunction

    task automatic push_frame(int i, logic [7:0] word);
        int n;
        n = flen_of(iw[i]);
        for (int k = 0; k < n; k++)
            exp_q[i].push_back('{v: 1'b1, b: frame_bit(word, iw[i], k), s: (k == 0), l: (k == n - 1)});
        for (int k = 0; k < ig[i]; k++)
            exp_q[i].push_back('0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v = '0;
        for (int i = 0; i < NI; i++) d[i] = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bv, bo, fs, fl, bsy, rdy} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got bv=%b bo=%b fs=%b fl=%b busy=%b rdy=%b, want all 0",
                     bv, bo, fs, fl, bsy, rdy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (rdy !== '1 || bsy !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%b busy=%b, want rdy=111 busy=000", rdy, bsy);
        end
    endtask

    task automatic test_a5_and_hold_off();
        int n;
        logic [7:0] w;
        cyc_t want;
        n = flen_of(W0);
        w = 8'hA5;
        @(negedge clk);
        d[0] = w;
        v[0] = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            want = '{v: 1'b1, b: frame_bit(w, W0, k), s: (k == 0), l: (k == n - 1)};
            vectors++;
            if ({bv[0], bo[0], fs[0], fl[0]} !== want || rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL a5_bit%0d: got v/b/s/l=%b rdy=%b busy=%b, want %b rdy=0 busy=1",
                         k, {bv[0], bo[0], fs[0], fl[0]}, rdy[0], bsy[0], want);
            end
            d[0] = 8'($urandom);
        end
        @(negedge clk);
        vectors++;
        if (bv[0] !== 1'b0 || rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_gap: got bv=%b rdy=%b busy=%b, want bv=0 rdy=0 busy=1", bv[0], rdy[0], bsy[0]);
        end
        d[0] = 8'h5A;
        @(negedge clk);
        vectors++;
        if (bv[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_idle: got bv=%b rdy=%b busy=%b, want bv=0 rdy=1 busy=0", bv[0], rdy[0], bsy[0]);
        end
        @(negedge clk);
        v[0] = 1'b0;
        vectors++;
        if ({bv[0], bo[0], fs[0]} !== 3'b101) begin
            miscompares++;
            $display("FAIL held_word_start: got v/b/s=%b, want 101", {bv[0], bo[0], fs[0]});
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, kk;
        logic [7:0] w;
        cyc_t want;
        n = flen_of(W1);
        @(negedge clk);
        d[1] = 8'hFF;
        v[1] = 1'b1;
        for (int k = 0; k < 2 * n; k++) begin
            @(negedge clk);
            w = (k < n) ? 8'hFF : 8'h00;
            kk = k % n;
            want = '{v: 1'b1, b: frame_bit(w, W1, kk), s: (kk == 0), l: (kk == n - 1)};
            vectors++;
            if ({bv[1], bo[1], fs[1], fl[1]} !== want || rdy[1] !== (kk == n - 1)) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got v/b/s/l=%b rdy=%b, want %b rdy=%b",
                         k + 1, {bv[1], bo[1], fs[1], fl[1]}, rdy[1], want, (kk == n - 1));
            end
            d[1] = 8'h00;
            if (k >= n) v[1] = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (bv[1] !== 1'b0 || rdy[1] !== 1'b1 || bsy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got bv=%b rdy=%b busy=%b, want bv=0 rdy=1 busy=0", bv[1], rdy[1], bsy[1]);
        end
    endtask

    task automatic test_width1();
        int n;
        cyc_t want;
        n = flen_of(W2);
        @(negedge clk);
        d[2] = 8'h01;
        v[2] = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v[2] = 1'b0;
            want = '{v: 1'b1, b: frame_bit(8'h01, W2, k), s: (k == 0), l: (k == n - 1)};
            vectors++;
            if ({bv[2], bo[2], fs[2], fl[2]} !== want) begin
                miscompares++;
                $display("FAIL w1_bit%0d: got v/b/s/l=%b, want %b", k, {bv[2], bo[2], fs[2], fl[2]}, want);
            end
        end
        for (int k = 0; k < G2; k++) begin
            @(negedge clk);
            vectors++;
            if (bv[2] !== 1'b0 || rdy[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_gap%0d: got bv=%b rdy=%b, want bv=0 rdy=0", k, bv[2], rdy[2]);
            end
        end
        @(negedge clk);
        vectors++;
        if (rdy[2] !== 1'b1 || bsy[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL w1_idle: got rdy=%b busy=%b, want rdy=1 busy=0", rdy[2], bsy[2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        cyc_t want;
        @(negedge clk);
        d[0] = 8'h3C;
        v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v[0] = 1'b0;
            want = '{v: 1'b1, b: frame_bit(8'h3C, W0, k), s: (k == 0), l: 1'b0};
            vectors++;
            if ({bv[0], bo[0], fs[0], fl[0]} !== want) begin
                miscompares++;
                $display("FAIL mid_bit%0d: got v/b/s/l=%b, want %b", k, {bv[0], bo[0], fs[0], fl[0]}, want);
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bv[0], fl[0], bsy[0], rdy[0], bo[0], fs[0]} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got bv=%b fl=%b busy=%b rdy=%b bo=%b fs=%b, want all 0",
                     bv[0], fl[0], bsy[0], rdy[0], bo[0], fs[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || bv[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_release: got rdy=%b busy=%b bv=%b, want 1 0 0", rdy[0], bsy[0], bv[0]);
        end
        @(negedge clk);
        d[0] = 8'h3C;
        v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v[0] = 1'b0;
            want = '{v: 1'b1, b: frame_bit(8'h3C, W0, k), s: (k == 0), l: 1'b0};
            vectors++;
            if ({bv[0], bo[0], fs[0], fl[0]} !== want) begin
                miscompares++;
                $display("FAIL restart_bit%0d: got v/b/s/l=%b, want %b", k, {bv[0], bo[0], fs[0], fl[0]}, want);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        cyc_t head;
        logic [NI-1:0] er;
        logic eb;
        for (int i = 0; i < NI; i++) exp_q[i].delete();
        repeat (400) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                head  = (exp_q[i].size() != 0) ? exp_q[i][0] : '0;
                er[i] = (exp_q[i].size() == 0) || (exp_q[i].size() == 1 && ig[i] == 0);
                eb    = (exp_q[i].size() != 0);
                vectors++;
                if ({bv[i], bo[i], fs[i], fl[i]} !== head || rdy[i] !== er[i] || bsy[i] !== eb) begin
                    miscompares++;
                    $display("FAIL rand_inst%0d: got v/b/s/l=%b rdy=%b busy=%b, want %b rdy=%b busy=%b",
                             i, {bv[i], bo[i], fs[i], fl[i]}, rdy[i], bsy[i], head, er[i], eb);
                end
            end
            for (int i = 0; i < NI; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                d[i] = 8'($urandom);
                if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                if (v[i] && er[i]) push_frame(i, d[i]);
            end
        end
        v = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a5_and_hold_off();
        test_back_to_back();
        test_width1();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_feeder.md
Name: serial_frame_feeder

Overview:
- Upstream stage for the serial pattern-checker FSM. Accepts parallel words over a valid/ready handshake and emits them MSB-first, one bit per clk, on bit_out.
- Provides frame markers so downstream logic knows where each word starts and ends.
- Enforces a configurable idle gap between frames.

Parameters:
- WIDTH, 8: data bits per frame; legal range 1..32.
- GAP, 1: idle cycles inserted after each frame's last bit; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialise.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  feeder can accept a word this cycle.
- bit_out  output  1  serial data bit, MSB first.
- bit_valid  output  1  bit_out carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of a frame.
- frame_last  output  1  high with the final bit of a frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- States: IDLE, SHIFT, GAP. Registers: shift register (WIDTH bits), bit counter, gap counter.
- Reset values:
  - state = IDLE.
  - bit_out, bit_valid, frame_start, frame_last, busy all 0.
  - Counters and shift register cleared.
  - in_ready forced 0 while rst is high.
- Reset mid-frame: the frame is dropped immediately. No frame_last is emitted. After rst deasserts, the block is in IDLE.
- Handshake:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready is combinational: (state==IDLE) || (state==SHIFT && final bit being driven && GAP==0).
  - in_data is sampled only on a transfer. in_data changes while in_ready=0 are ignored.
- Latency: the first bit appears on bit_out in the cycle immediately after the accepting edge. Data-path outputs are registered.
- SHIFT state:
  - Each cycle drives bit_out = shift register MSB with bit_valid=1, then shifts left by one.
  - frame_start=1 only on the first bit. frame_last=1 only on the final bit.
  - WIDTH=1: frame_start and frame_last are high in the same cycle.
- After the final bit:
  - If GAP>0: go to GAP. bit_valid=0 for exactly GAP cycles, then go to IDLE.
  - If GAP==0 and a transfer occurs on that edge: stay in SHIFT, reload, and emit the new frame's first bit with frame_start=1 next cycle. This gives back-to-back frames with no bubble.
  - If GAP==0 and there is no transfer: go to IDLE.
- IDLE: bit_valid=0. bit_out holds 0.
- busy = 1 in SHIFT and GAP, 0 in IDLE.
- No other simultaneous events are possible, because in_ready is low during mid-frame SHIFT cycles and during GAP.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - One extra bit is appended after the WIDTH data bits: even parity, i.e. the XOR of all data bits, so the total count of ones in the frame is even.
  - Frame length is WIDTH+1. frame_last moves to the parity bit.
  - The in_ready early-assert for GAP==0 moves to the parity-bit cycle.
- Undefined: frame length is WIDTH and no parity logic is present.

Test Plan:
- Reset then transfer, WIDTH=8, GAP=1, in_data=8'hA5:
  - Next 8 cycles bit_out = 1,0,1,0,0,1,0,1 with bit_valid=1.
  - frame_start on cycle 1, frame_last on cycle 8.
  - Then 1 cycle with bit_valid=0, then in_ready=1.
- GAP=0, in_valid held high with 8'hFF then 8'h00:
  - 16 consecutive bit_valid cycles: eight 1s then eight 0s.
  - frame_start on cycles 1 and 9; no bubble.
- in_valid pulsed during SHIFT and GAP:
  - in_ready=0, no transfer, output stream unchanged.
  - The word is accepted only once IDLE is reached.
- rst asserted at bit 4 of 8'h3C:
  - bit_valid, frame_last and busy go to 0 immediately.
  - After rst deasserts, in_ready=1 and the next frame starts clean.
- WIDTH=1, in_data=1: one cycle with bit_out=1, frame_start=1, frame_last=1.
- SERIAL_FEEDER_PARITY_EN defined, in_data=8'h07: 9 bits 0,0,0,0,0,1,1,1,1, with frame_last on the 9th bit (parity=1).
